// File: rtl/sync_timing_generator.sv
// One axis of a raster timing generator: a counter walks ACTIVE/FRONT/SYNC/BACK
// regions, and registered outputs always agree with the registered counter and state.
module sync_timing_generator #(
    parameter int ACTIVE          = 640,
    parameter int FRONT_PORCH     = 16,
    parameter int SYNC_PULSE      = 96,
    parameter int BACK_PORCH      = 48,
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int COUNTER_SIZE    = 11
) (
    input  logic                    control_clock,
    input  logic                    reset_n,
    input  logic                    advance,
    output logic                    sync,
    output logic                    display_enable,
    output logic [COUNTER_SIZE-1:0] counter,
    output logic                    terminal
);

    localparam int     TOTAL     = ACTIVE + FRONT_PORCH + SYNC_PULSE + BACK_PORCH;
    localparam longint MAX_COUNT = (longint'(1) << COUNTER_SIZE) - 1;

    // Last count of each region; a region of length 1 starts and ends on the same count.
    localparam logic [COUNTER_SIZE-1:0] ACTIVE_LAST = COUNTER_SIZE'(ACTIVE - 1);
    localparam logic [COUNTER_SIZE-1:0] FRONT_LAST  = COUNTER_SIZE'(ACTIVE + FRONT_PORCH - 1);
    localparam logic [COUNTER_SIZE-1:0] SYNC_LAST   = COUNTER_SIZE'(ACTIVE + FRONT_PORCH + SYNC_PULSE - 1);
    localparam logic [COUNTER_SIZE-1:0] TOTAL_LAST  = COUNTER_SIZE'(TOTAL - 1);

    localparam logic SYNC_ON  = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam logic SYNC_OFF = ~SYNC_ON;

    localparam logic [3:0] PARAM_BAD = {BACK_PORCH < 1, SYNC_PULSE < 1, FRONT_PORCH < 1, ACTIVE < 1};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gen_param_check
            if (PARAM_BAD[gi]) begin : gen_bad
                $error("timing parameter %0d (0=ACTIVE..3=BACK_PORCH) must be at least 1", gi);
            end
        end
        if (longint'(TOTAL) - 1 > MAX_COUNT) begin : gen_counter_too_small
            $error("TOTAL-1 does not fit in COUNTER_SIZE bits");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_FRONT,
        ST_SYNC,
        ST_BACK
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [COUNTER_SIZE-1:0] counter_reg;
    logic [COUNTER_SIZE-1:0] counter_next;
    logic                    display_enable_reg;
    logic                    display_enable_next;
    logic                    sync_reg;
    logic                    sync_next;
    logic                    terminal_reg;
    logic                    terminal_next;

    always_ff @(posedge control_clock) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            counter_reg <= '0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        if (advance) begin
            if (state_reg == ST_IDLE) begin
                state_next   = ST_ACTIVE;
                counter_next = '0;
            end else if (counter_reg == TOTAL_LAST) begin
                state_next   = ST_ACTIVE;
                counter_next = '0;
            end else begin
                counter_next = counter_reg + 1'b1;
                case (state_reg)
                    ST_ACTIVE: if (counter_reg == ACTIVE_LAST) state_next = ST_FRONT;
                    ST_FRONT:  if (counter_reg == FRONT_LAST)  state_next = ST_SYNC;
                    ST_SYNC:   if (counter_reg == SYNC_LAST)   state_next = ST_BACK;
                    default:   state_next = state_reg;
                endcase
            end
        end
    end

    // Outputs are decoded from the upcoming state so that, once registered,
    // they line up with counter_reg/state_reg in the same cycle.
    always_comb begin
        display_enable_next = (state_next == ST_ACTIVE);
        sync_next           = (state_next == ST_SYNC) ? SYNC_ON : SYNC_OFF;
        terminal_next       = (state_next == ST_BACK) && (counter_next == TOTAL_LAST);
    end

    always_ff @(posedge control_clock) begin
        if (!reset_n) begin
            display_enable_reg <= 1'b0;
            sync_reg           <= SYNC_OFF;
            terminal_reg       <= 1'b0;
        end else begin
            display_enable_reg <= display_enable_next;
            sync_reg           <= sync_next;
            terminal_reg       <= terminal_next;
        end
    end

    assign sync           = sync_reg;
    assign display_enable = display_enable_reg;
    assign counter        = counter_reg;
    assign terminal       = terminal_reg;

endmodule

// File: tb/tb_sync_timing_generator.sv
// Directed bench: horizontal (4,1,2,1), cascaded vertical (2,1,1,1) and an
// active-high-sync copy of the horizontal, all checked every clock.
module tb_sync_timing_generator;

    logic       control_clock = 1'b0;
    logic       reset_n;
    logic       advance;

    logic       h_sync, h_de, h_term;
    logic [2:0] h_cnt;
    logic       v_sync, v_de, v_term;
    logic [2:0] v_cnt;
    logic       p_sync, p_de, p_term;
    logic [2:0] p_cnt;
    logic       v_advance;

    assign v_advance = advance & h_term;

    always #5 control_clock = ~control_clock;

    sync_timing_generator #(
        .ACTIVE(4), .FRONT_PORCH(1), .SYNC_PULSE(2), .BACK_PORCH(1),
        .SYNC_ACTIVE_LOW(1'b1), .COUNTER_SIZE(3)
    ) u_h (
        .control_clock(control_clock), .reset_n(reset_n), .advance(advance),
        .sync(h_sync), .display_enable(h_de), .counter(h_cnt), .terminal(h_term)
    );

    sync_timing_generator #(
        .ACTIVE(2), .FRONT_PORCH(1), .SYNC_PULSE(1), .BACK_PORCH(1),
        .SYNC_ACTIVE_LOW(1'b1), .COUNTER_SIZE(3)
    ) u_v (
        .control_clock(control_clock), .reset_n(reset_n), .advance(v_advance),
        .sync(v_sync), .display_enable(v_de), .counter(v_cnt), .terminal(v_term)
    );

    sync_timing_generator #(
        .ACTIVE(4), .FRONT_PORCH(1), .SYNC_PULSE(2), .BACK_PORCH(1),
        .SYNC_ACTIVE_LOW(1'b0), .COUNTER_SIZE(3)
    ) u_p (
        .control_clock(control_clock), .reset_n(reset_n), .advance(advance),
        .sync(p_sync), .display_enable(p_de), .counter(p_cnt), .terminal(p_term)
    );

    int n_cmp   = 0;
    int n_bad   = 0;
    int edge_no = 0;

    // Expected position: idle flag plus count, for horizontal and vertical.
    bit m_h_idle = 1'b1;
    int m_h_cnt  = 0;
    bit m_v_idle = 1'b1;
    int m_v_cnt  = 0;

    // Hand-decoded region tables, bit i = value at count i.
    logic [7:0] h_de_tab   = 8'b0000_1111;
    logic [7:0] h_sync_tab = 8'b0110_0000;
    logic [7:0] h_term_tab = 8'b1000_0000;
    logic [4:0] v_de_tab   = 5'b00011;
    logic [4:0] v_sync_tab = 5'b01000;
    logic [4:0] v_term_tab = 5'b10000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0d want %0d", tag, edge_no, got, want);
        end
    endtask

    task automatic check_all();
        logic h_run, v_run;
        h_run = !m_h_idle;
        v_run = !m_v_idle;
        check("h_cnt",  h_cnt,  m_h_cnt);
        check("h_de",   h_de,   h_run & h_de_tab[m_h_cnt]);
        check("h_sync", h_sync, !(h_run & h_sync_tab[m_h_cnt]));
        check("h_term", h_term, h_run & h_term_tab[m_h_cnt]);
        check("p_cnt",  p_cnt,  m_h_cnt);
        check("p_de",   p_de,   h_run & h_de_tab[m_h_cnt]);
        check("p_sync", p_sync, h_run & h_sync_tab[m_h_cnt]);
        check("p_term", p_term, h_run & h_term_tab[m_h_cnt]);
        check("v_cnt",  v_cnt,  m_v_cnt);
        check("v_de",   v_de,   v_run & v_de_tab[m_v_cnt]);
        check("v_sync", v_sync, !(v_run & v_sync_tab[m_v_cnt]));
        check("v_term", v_term, v_run & v_term_tab[m_v_cnt]);
    endtask

    task automatic step(input logic adv, input logic rst_n_in);
        bit h_term_pre;
        advance    = adv;
        reset_n    = rst_n_in;
        h_term_pre = !m_h_idle && (m_h_cnt == 7);
        @(posedge control_clock);
        #1;
        edge_no++;
        if (!rst_n_in) begin
            m_h_idle = 1'b1; m_h_cnt = 0;
            m_v_idle = 1'b1; m_v_cnt = 0;
        end else begin
            if (adv && h_term_pre) begin
                if (m_v_idle) begin
                    m_v_idle = 1'b0; m_v_cnt = 0;
                end else begin
                    m_v_cnt = (m_v_cnt == 4) ? 0 : m_v_cnt + 1;
                end
            end
            if (adv) begin
                if (m_h_idle) begin
                    m_h_idle = 1'b0; m_h_cnt = 0;
                end else begin
                    m_h_cnt = (m_h_cnt == 7) ? 0 : m_h_cnt + 1;
                end
            end
        end
        check_all();
    endtask

    int seq_c [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

    initial begin
        reset_n = 1'b0;
        advance = 1'b0;

        // Reset wins over advance.
        repeat (2) step(1'b1, 1'b0);
        // Released but not advancing: stays idle at reset values.
        repeat (3) step(1'b0, 1'b1);

        // Continuous advance: one full period plus wrap.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b1);
            check("seq_cnt", h_cnt, seq_c[i]);
        end

        // Five more horizontal periods: vertical returns to 0.
        repeat (40) step(1'b1, 1'b1);
        check("v_wrap_cnt", v_cnt, 0);
        check("h_wrap_cnt", h_cnt, 0);

        // Advance toggling every cycle: each count held two cycles.
        for (int i = 0; i < 32; i++) step((i % 2) == 0, 1'b1);
        check("toggle_end_cnt", h_cnt, 0);

        // Run to count 6 (sync asserted), then reset mid-period.
        for (int i = 0; i < 16 && !(m_h_cnt == 6 && !m_h_idle); i++) step(1'b1, 1'b1);
        check("at6_sync", h_sync, 1'b0);
        step(1'b1, 1'b0);
        check("rst6_sync", h_sync, 1'b1);
        repeat (3) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check("restart_cnt", h_cnt, 0);
        check("restart_de", h_de, 1'b1);
        repeat (3) step(1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
